dr_uart_tx: RTL and testbench

//  Host-side transmitter for the CPU debug register (written by CPDR, opcode D3).

---
 rtl/dr_uart_tx_if.sv | 26 ++
 rtl/dr_uart_tx.sv | 186 ++++++++++++++++++
 tb/tb_dr_uart_tx.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dr_uart_tx_if.sv
// Debug-register UART transmitter bus: CPDR write strobe/data in, serial line and status out.
interface dr_uart_tx_if;
    logic        dr_we;
    logic [31:0] dr_data;
    logic        txd;
    logic        busy;
    logic        overflow;

    // Transmitter side
    modport slave (
        input  dr_we,
        input  dr_data,
        output txd,
        output busy,
        output overflow
    );

    // Core / host side driving CPDR writes
    modport master (
        output dr_we,
        output dr_data,
        input  txd,
        input  busy,
        input  overflow
    );
endinterface

// File: rtl/dr_uart_tx.sv
// CPDR debug-register transmitter.
// Each dr_we captures a 32-bit word into a small FIFO; words are sent as
// eight uppercase hex characters followed by CR LF, 8N1, LSB first, idle high.
//
// state  | meaning
// IDLE   | line idle; pops the FIFO head into the shadow word when non-empty
// START  | start bit (txd=0) for CLK_DIV cycles
// DATA   | data bits 0..7 of the current character, CLK_DIV cycles each
// STOP   | stop bit (txd=1); then next character or back to IDLE after LF
module dr_uart_tx #(
    parameter int CLK_DIV = 868,
    parameter int FIFO_AW = 2
) (
    input  logic         clk,
    input  logic         reset,
    dr_uart_tx_if.slave  bus
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = FIFO_AW + 1;

    localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [3:0] LAST_CHAR = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        baud_q, baud_d;
    logic [2:0]         bit_q, bit_d;
    logic [3:0]         char_q, char_d;
    logic [31:0]        shadow_q, shadow_d;
    logic               txd_q, txd_d;
    logic               ovf_q, ovf_d;
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [31:0]        mem_q [DEPTH];

    logic               pop;
    logic               push;
    logic               bit_done;
    logic [31:0]        head;
    logic [7:0]         char_next;

    // ASCII code of character idx of a word: hex nibbles MSB first, then CR, LF
    function automatic logic [7:0] char_code(input logic [31:0] w, input logic [3:0] idx);
        logic [4:0] sh;
        logic [3:0] nib;
        logic [7:0] code;
        sh  = 5'd28 - {idx[2:0], 2'b00};
        nib = w[sh +: 4];
        if (idx == 4'd8) begin
            code = 8'h0D;
        end else if (idx == 4'd9) begin
            code = 8'h0A;
        end else if (nib < 4'd10) begin
            code = 8'h30 + {4'h0, nib};
        end else begin
            code = 8'h37 + {4'h0, nib};
        end
        return code;
    endfunction

    // FIFO bookkeeping: a push is allowed into a full FIFO only when the head leaves this cycle
    always_comb begin
        head     = mem_q[rd_ptr_q];
        pop      = (state_q == S_IDLE) && (count_q != '0);
        push     = bus.dr_we && ((count_q != FULL_CNT) || pop);
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        ovf_d    = ovf_q | (bus.dr_we & ~push);
    end

    // Next-state logic for the character/bit sequencer and the registered txd level
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        char_d    = char_q;
        shadow_d  = shadow_q;
        bit_done  = (baud_q == BAUD_LAST);

        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                if (pop) begin
                    shadow_d = head;
                    char_d   = '0;
                    state_d  = S_START;
                end
            end
            S_START: begin
                if (bit_done) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            S_STOP: begin
                if (bit_done) begin
                    baud_d = '0;
                    if (char_q < LAST_CHAR) begin
                        char_d  = char_q + 4'd1;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                baud_d  = '0;
            end
        endcase

        // txd is driven from a flop so the line never glitches between bits
        char_next = char_code(shadow_d, char_d);
        case (state_d)
            S_START: txd_d = 1'b0;
            S_DATA:  txd_d = char_next[bit_d];
            default: txd_d = 1'b1;
        endcase
    end

    // Control and status registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            char_q   <= '0;
            shadow_q <= '0;
            txd_q    <= 1'b1;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            char_q   <= char_d;
            shadow_q <= shadow_d;
            txd_q    <= txd_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage; contents are don't-care until written, so no reset is needed
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem_q[wr_ptr_q] <= bus.dr_data;
        end
    end

    assign bus.txd      = txd_q;
    assign bus.busy     = (state_q != S_IDLE) || (count_q != '0);
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_dr_uart_tx.sv
// Bench for dr_uart_tx: frame-level reference model checked every cycle,
// plus a mid-bit UART receiver whose decoded bytes are compared to literal strings.
module tb_dr_uart_tx;
    localparam int CLK_DIV = 4;
    localparam int FIFO_AW = 2;
    localparam int DEPTH   = 4;
    localparam int CHAR_T  = 10 * CLK_DIV;
    localparam int FRAME   = 10 * CHAR_T;

    logic clk = 1'b0;
    logic reset;
    dr_uart_tx_if bus ();

    dr_uart_tx #(.CLK_DIV(CLK_DIV), .FIFO_AW(FIFO_AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: character c of a word as the text "%08X\r\n" would print it
    function automatic logic [7:0] char_of(input logic [31:0] w, input int c);
        string s;
        logic [7:0] ch;
        if (c == 8) return 8'h0D;
        if (c == 9) return 8'h0A;
        s  = $sformatf("%08h", w);
        ch = s[c];
        if (ch >= 8'h61 && ch <= 8'h66) ch = ch - 8'h20;
        return ch;
    endfunction

    // Reference: line level at cycle t of a 10-character frame
    function automatic logic frame_bit(input logic [31:0] w, input int t);
        int c;
        int b;
        logic [7:0] ch;
        c = t / CHAR_T;
        b = (t % CHAR_T) / CLK_DIV;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        ch = char_of(w, c);
        return ch[b-1];
    endfunction

    // ---------------- reference model (updated on every clock edge) ----------------
    logic [31:0] mq[$];
    logic [31:0] m_word;
    bit          m_active = 0;
    bit          m_pop;
    int          m_t = 0;
    bit          m_ovf = 0;
    bit          m_txd = 1;
    bit          m_busy = 0;
    bit          m_valid = 0;

    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            m_active = 0;
            m_t      = 0;
            m_ovf    = 0;
            m_valid  = 1;
        end else begin
            m_pop = 0;
            if (m_active) begin
                if (m_t == FRAME - 1) m_active = 0;
                else m_t++;
            end else if (mq.size() != 0) begin
                m_word   = mq.pop_front();
                m_pop    = 1;
                m_active = 1;
                m_t      = 0;
            end
            // size is already post-pop here, so a same-cycle pop frees the slot
            if (bus.dr_we) begin
                if (mq.size() < DEPTH) mq.push_back(bus.dr_data);
                else m_ovf = 1;
            end
        end
        m_txd  = m_active ? frame_bit(m_word, m_t) : 1'b1;
        m_busy = m_active || (mq.size() != 0);
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (m_valid) begin
            check("txd", bus.txd, m_txd);
            check("busy", bus.busy, m_busy);
            check("overflow", bus.overflow, m_ovf);
        end
    end

    // ---------------- mid-bit UART receiver ----------------
    logic [7:0] rx_q[$];
    logic [7:0] rx_sh;
    bit         rx_busy = 0;
    int         rx_cnt = 0;

    always @(negedge clk) begin
        if (reset) begin
            rx_busy = 0;
        end else if (!rx_busy) begin
            if (bus.txd === 1'b0) begin
                rx_busy = 1;
                rx_cnt  = 0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt % CLK_DIV == CLK_DIV / 2) begin
                if (rx_cnt / CLK_DIV >= 1 && rx_cnt / CLK_DIV <= 8) begin
                    rx_sh[rx_cnt / CLK_DIV - 1] = bus.txd;
                end else if (rx_cnt / CLK_DIV == 9) begin
                    check("rx_stop_bit", bus.txd, 1'b1);
                    rx_q.push_back(rx_sh);
                    rx_busy = 0;
                end
            end
        end
    end

    // ---------------- stimulus helpers (enter and leave at posedge+1) ----------------
    task automatic drive(input logic [31:0] d);
        bus.dr_we   = 1'b1;
        bus.dr_data = d;
        @(posedge clk);
        #1;
        bus.dr_we   = 1'b0;
        bus.dr_data = $urandom;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            bus.dr_data = $urandom;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_reset(input bit with_we);
        reset       = 1'b1;
        bus.dr_we   = with_we;
        bus.dr_data = 32'hDEAD0000;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        bus.dr_we = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget, output int n);
        n = 0;
        while (bus.busy !== 1'b0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_done_in_budget"}, (n < budget), 1'b1);
        idle(2);
    endtask

    task automatic check_line(input string name, input logic [79:0] exp);
        logic [7:0] got;
        for (int i = 0; i < 10; i++) begin
            got = (rx_q.size() != 0) ? rx_q.pop_front() : 8'hXX;
            check($sformatf("%s_byte%0d", name, i), got, exp[79 - 8*i -: 8]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset       = 1'b1;
        bus.dr_we   = 1'b0;
        bus.dr_data = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // model pinned by hand-derived characters
        check("model_char_B", char_of(32'h0000ABCD, 5), 8'h42);
        check("model_char_F", char_of(32'h9F00A5E1, 1), 8'h46);
        check("model_char_LF", char_of(32'h0, 9), 8'h0A);

        // T6: long idle
        idle(1000);
        check("t6_txd", bus.txd, 1'b1);
        check("t6_busy", bus.busy, 1'b0);

        // T1: "0000ABCD\r\n"
        rx_q.delete();
        drive(32'h0000ABCD);
        wait_idle("t1", 600, n);
        check("t1_busy_cycles", n, 401);
        check("t1_rx_count", rx_q.size(), 10);
        check_line("t1", 80'h30303030414243440D0A);

        // T2: latency and "9F00A5E1\r\n"
        rx_q.delete();
        drive(32'h9F00A5E1);
        check("t2_txd_pop_cycle", bus.txd, 1'b1);
        idle(1);
        check("t2_txd_first_start", bus.txd, 1'b0);
        wait_idle("t2", 600, n);
        check("t2_busy_low", bus.busy, 1'b0);
        check_line("t2", 80'h39463030413545310D0A);

        // T3: six consecutive writes, sixth dropped
        pulse_reset(1'b0);
        rx_q.delete();
        for (int k = 1; k <= 6; k++) drive(32'(k));
        check("t3_overflow", bus.overflow, 1'b1);
        wait_idle("t3", 6 * 401 + 100, n);
        check("t3_rx_count", rx_q.size(), 50);
        for (int k = 1; k <= 5; k++) begin
            check_line($sformatf("t3_word%0d", k), {56'h30303030303030, 8'(8'h30 + k), 16'h0D0A});
        end
        check("t3_overflow_sticky", bus.overflow, 1'b1);

        // T4: write on the pop cycle of a full FIFO is accepted
        pulse_reset(1'b0);
        rx_q.delete();
        drive(32'h11111111);
        drive(32'h22222222);
        drive(32'h33333333);
        drive(32'h44444444);
        drive(32'h55555555);
        idle(397);
        drive(32'hCAFEF00D);
        check("t4_overflow", bus.overflow, 1'b0);
        wait_idle("t4", 6 * 401 + 100, n);
        check("t4_rx_count", rx_q.size(), 60);
        repeat (50) void'(rx_q.pop_front());
        check_line("t4_last", 80'h43414645463030440D0A);

        // T5: reset in DATA of char 3, with a write strobe during reset
        pulse_reset(1'b0);
        rx_q.delete();
        drive(32'h12345678);
        idle(131);
        pulse_reset(1'b1);
        check("t5_txd", bus.txd, 1'b1);
        check("t5_busy", bus.busy, 1'b0);
        check("t5_overflow", bus.overflow, 1'b0);
        idle(3);
        rx_q.delete();
        drive(32'h00C0FFEE);
        wait_idle("t5", 600, n);
        check("t5_rx_count", rx_q.size(), 10);
        check_line("t5", 80'h30304330464645450D0A);

        idle(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
